// File: rtl/conv2_maxpool.sv
// 2x2 stride-2 max pool for one conv2 output channel, raster-order input, registered output.
// Optional build macro: CONV2_POOL_RELU_EN fuses a ReLU after the pool.
module conv2_maxpool #(
  parameter int WIDTH     = 8,
  parameter int HEIGHT    = 8,
  parameter int DATA_BITS = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic [DATA_BITS-1:0] conv_in,
  output logic [DATA_BITS-1:0] max_out,
  output logic                 valid_out,
  output logic                 frame_done
);

  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int LD = (WIDTH  > 1) ? WIDTH / 2      : 1;
  localparam int LW = (LD     > 1) ? $clog2(LD)     : 1;

  if ((WIDTH % 2) != 0) begin : g_bad_width
    $error("conv2_maxpool: WIDTH must be even");
  end
  if ((HEIGHT % 2) != 0) begin : g_bad_height
    $error("conv2_maxpool: HEIGHT must be even");
  end

  function automatic logic signed [DATA_BITS-1:0] smax(
    input logic signed [DATA_BITS-1:0] a,
    input logic signed [DATA_BITS-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  logic [CW-1:0]                col_q, col_d;
  logic [RW-1:0]                row_q, row_d;
  logic signed [DATA_BITS-1:0]  hold_q, hold_d;
  logic [DATA_BITS-1:0]         max_out_q, max_out_d;
  logic                         valid_out_q, valid_out_d;
  logic                         frame_done_q, frame_done_d;

  logic signed [DATA_BITS-1:0]  linebuf_q [LD];
  logic [LW-1:0]                lb_idx;
  logic                         lb_we;
  logic signed [DATA_BITS-1:0]  pair_max;
  logic signed [DATA_BITS-1:0]  result;
  logic                         last_col, last_row;

  assign lb_idx   = LW'(col_q >> 1);
  assign last_col = (col_q == CW'(WIDTH - 1));
  assign last_row = (row_q == RW'(HEIGHT - 1));
  assign pair_max = smax(hold_q, $signed(conv_in));
  assign result   = smax(linebuf_q[lb_idx], pair_max);

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    hold_d       = hold_q;
    max_out_d    = max_out_q;
    valid_out_d  = 1'b0;
    frame_done_d = 1'b0;
    lb_we        = 1'b0;
    if (valid_in) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      if (!col_q[0]) begin
        hold_d = $signed(conv_in);
      end else if (!row_q[0]) begin
        lb_we = 1'b1;
      end else begin
        // Odd row, odd column closes a 2x2 window: publish its maximum next edge.
`ifdef CONV2_POOL_RELU_EN
        max_out_d = result[DATA_BITS-1] ? '0 : result;
`else
        max_out_d = result;
`endif
        valid_out_d  = 1'b1;
        frame_done_d = last_row && last_col;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      hold_q       <= '0;
      max_out_q    <= '0;
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      hold_q       <= hold_d;
      max_out_q    <= max_out_d;
      valid_out_q  <= valid_out_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffer holds even-row pair maxima until the odd row consumes them; no reset needed.
  always_ff @(posedge clk) begin
    if (lb_we && !rst) begin
      linebuf_q[lb_idx] <= pair_max;
    end
  end

  assign max_out    = max_out_q;
  assign valid_out  = valid_out_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv2_maxpool.sv
// Self-checking bench for conv2_maxpool (WIDTH=4, HEIGHT=4) against a frame-array reference model.
module tb_conv2_maxpool;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DB = 14;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_in = 1'b0;
  logic [DB-1:0] conv_in = '0;
  logic [DB-1:0] max_out;
  logic          valid_out;
  logic          frame_done;

  int errors = 0;
  int checks = 0;

  int            img [H][W];
  int            pix = 0;
  logic          exp_valid = 1'b0;
  logic          exp_fd = 1'b0;
  logic [DB-1:0] exp_max = '0;
  int            outs [$];
  int            fd_vals [$];

  conv2_maxpool #(.WIDTH(W), .HEIGHT(H), .DATA_BITS(DB)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .conv_in    (conv_in),
    .max_out    (max_out),
    .valid_out  (valid_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Drive one cycle and update the pooled-frame model; the result is due one edge later.
  task automatic drive_cycle(input bit r, input bit v, input int d);
    int row, col, m;
    rst      = r;
    valid_in = v;
    conv_in  = DB'(d);
    exp_valid = 1'b0;
    exp_fd    = 1'b0;
    if (r) begin
      pix = 0;
      exp_max = '0;
    end else if (v) begin
      row = pix / W;
      col = pix % W;
      img[row][col] = d;
      if ((row % 2 == 1) && (col % 2 == 1)) begin
        m = img[row-1][col-1];
        if (img[row-1][col] > m) m = img[row-1][col];
        if (img[row][col-1]   > m) m = img[row][col-1];
        if (img[row][col]     > m) m = img[row][col];
`ifdef CONV2_POOL_RELU_EN
        if (m < 0) m = 0;
`endif
        exp_max   = DB'(m);
        exp_valid = 1'b1;
        exp_fd    = (pix == W*H - 1);
      end
      pix = (pix + 1) % (W*H);
    end
    @(posedge clk);
    #1;
    if (valid_out) outs.push_back(int'($signed(max_out)));
    if (frame_done) fd_vals.push_back(int'($signed(max_out)));
  endtask

  task automatic test_reset();
    drive_cycle(1'b1, 1'b1, 1234);
    drive_cycle(1'b1, 1'b0, 0);
    checks++;
    if (max_out !== '0) begin
      errors++; $display("[TB] FAIL reset_max_out: got %h want 0", max_out);
    end
    checks++;
    if (valid_out !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_valid_out: got %b want 0", valid_out);
    end
    checks++;
    if (frame_done !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_frame_done: got %b want 0", frame_done);
    end
    drive_cycle(1'b0, 1'b0, 0);
  endtask

  task automatic test_ramp();
    int exp_vals [4] = '{5, 7, 13, 15};
    outs.delete(); fd_vals.delete();
    for (int p = 0; p < 17; p++) begin
      drive_cycle(1'b0, p < 16, p);
      checks++;
      if (valid_out !== exp_valid || frame_done !== exp_fd || max_out !== exp_max) begin
        errors++;
        $display("[TB] FAIL ramp cyc%0d: got v=%b fd=%b max=%h want v=%b fd=%b max=%h",
                 p, valid_out, frame_done, max_out, exp_valid, exp_fd, exp_max);
      end
    end
    checks++;
    if (outs.size() != 4) begin
      errors++; $display("[TB] FAIL ramp_count: got %0d want 4", outs.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (outs[i] != exp_vals[i]) begin
          errors++; $display("[TB] FAIL ramp_val%0d: got %0d want %0d", i, outs[i], exp_vals[i]);
        end
      end
    end
    checks++;
    if (fd_vals.size() != 1 || fd_vals[0] != 15) begin
      errors++; $display("[TB] FAIL ramp_frame_done: got %0d pulses want one with 15", fd_vals.size());
    end
  endtask

  task automatic test_all_negative();
    logic [DB-1:0] want;
`ifdef CONV2_POOL_RELU_EN
    want = 14'h0000;
`else
    want = 14'h3FFD;
`endif
    outs.delete();
    for (int p = 0; p < 17; p++) begin
      drive_cycle(1'b0, p < 16, -3);
      checks++;
      if (valid_out !== exp_valid || max_out !== exp_max) begin
        errors++;
        $display("[TB] FAIL neg3 cyc%0d: got v=%b max=%h want v=%b max=%h",
                 p, valid_out, max_out, exp_valid, exp_max);
      end
      if (valid_out === 1'b1) begin
        checks++;
        if (max_out !== want) begin
          errors++; $display("[TB] FAIL neg3_value: got %h want %h", max_out, want);
        end
      end
    end
    checks++;
    if (outs.size() != 4) begin
      errors++; $display("[TB] FAIL neg3_count: got %0d want 4", outs.size());
    end
  endtask

  task automatic test_mixed_signs();
    int rows01 [8] = '{-8191, 100, 5, -1, -2, -3, 7, 6};
    outs.delete();
    for (int p = 0; p < 16; p++) begin
      drive_cycle(1'b0, 1'b1, (p < 8) ? rows01[p] : int'($urandom_range(0, 16383)) - 8192);
      checks++;
      if (valid_out !== exp_valid || frame_done !== exp_fd || max_out !== exp_max) begin
        errors++;
        $display("[TB] FAIL mixed cyc%0d: got v=%b fd=%b max=%h want v=%b fd=%b max=%h",
                 p, valid_out, frame_done, max_out, exp_valid, exp_fd, exp_max);
      end
    end
    checks++;
    if (outs.size() < 2 || outs[0] != 100 || outs[1] != 7) begin
      errors++;
      $display("[TB] FAIL mixed_first_two: got n=%0d first=%0d want 100 then 7",
               outs.size(), (outs.size() > 0) ? outs[0] : 0);
    end
  endtask

  task automatic test_gapped();
    int exp_vals [4] = '{5, 7, 13, 15};
    int p = 0;
    outs.delete();
    for (int k = 0; k < 50; k++) begin
      if (k % 3 == 2 && p < 16) begin
        drive_cycle(1'b0, 1'b1, p);
        p++;
      end else begin
        drive_cycle(1'b0, 1'b0, 999);
      end
      checks++;
      if (valid_out !== exp_valid || frame_done !== exp_fd || max_out !== exp_max) begin
        errors++;
        $display("[TB] FAIL gapped cyc%0d: got v=%b fd=%b max=%h want v=%b fd=%b max=%h",
                 k, valid_out, frame_done, max_out, exp_valid, exp_fd, exp_max);
      end
    end
    checks++;
    if (outs.size() != 4 || outs[0] != exp_vals[0] || outs[1] != exp_vals[1] ||
        outs[2] != exp_vals[2] || outs[3] != exp_vals[3]) begin
      errors++; $display("[TB] FAIL gapped_values: got %0d outputs want 5,7,13,15", outs.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    for (int p = 0; p < 6; p++) drive_cycle(1'b0, 1'b1, 40 + p);
    drive_cycle(1'b1, 1'b1, 77);
    outs.delete();
    checks++;
    if (valid_out !== 1'b0 || max_out !== '0) begin
      errors++; $display("[TB] FAIL midreset_clear: got v=%b max=%h want v=0 max=0", valid_out, max_out);
    end
    for (int p = 0; p < 17; p++) begin
      drive_cycle(1'b0, p < 16, p);
      checks++;
      if (valid_out !== exp_valid || frame_done !== exp_fd || max_out !== exp_max) begin
        errors++;
        $display("[TB] FAIL midreset cyc%0d: got v=%b fd=%b max=%h want v=%b fd=%b max=%h",
                 p, valid_out, frame_done, max_out, exp_valid, exp_fd, exp_max);
      end
    end
    checks++;
    if (outs.size() != 4 || outs[0] != 5 || outs[1] != 7 || outs[2] != 13 || outs[3] != 15) begin
      errors++; $display("[TB] FAIL midreset_values: got %0d outputs want 5,7,13,15", outs.size());
    end
  endtask

  task automatic test_back_to_back();
    int exp_vals [8] = '{5, 7, 13, 15, 21, 23, 29, 31};
    outs.delete(); fd_vals.delete();
    for (int p = 0; p < 33; p++) begin
      drive_cycle(1'b0, p < 32, p);
      checks++;
      if (valid_out !== exp_valid || frame_done !== exp_fd || max_out !== exp_max) begin
        errors++;
        $display("[TB] FAIL b2b cyc%0d: got v=%b fd=%b max=%h want v=%b fd=%b max=%h",
                 p, valid_out, frame_done, max_out, exp_valid, exp_fd, exp_max);
      end
    end
    checks++;
    if (outs.size() != 8) begin
      errors++; $display("[TB] FAIL b2b_count: got %0d want 8", outs.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (outs[i] != exp_vals[i]) begin
          errors++; $display("[TB] FAIL b2b_val%0d: got %0d want %0d", i, outs[i], exp_vals[i]);
        end
      end
    end
    checks++;
    if (fd_vals.size() != 2 || fd_vals[0] != 15 || fd_vals[1] != 31) begin
      errors++; $display("[TB] FAIL b2b_frame_done: got %0d pulses want 15 and 31", fd_vals.size());
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 200; k++) begin
      drive_cycle(1'b0, ($urandom_range(0, 3) != 0), int'($urandom_range(0, 16383)) - 8192);
      checks++;
      if (valid_out !== exp_valid || frame_done !== exp_fd || max_out !== exp_max) begin
        errors++;
        $display("[TB] FAIL random cyc%0d: got v=%b fd=%b max=%h want v=%b fd=%b max=%h",
                 k, valid_out, frame_done, max_out, exp_valid, exp_fd, exp_max);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_all_negative();
    test_mixed_signs();
    test_gapped();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
